// File: rtl/write_merge_buffer.sv
// Write merge buffer: collects byte writes into one line and drains it to the cache on a miss, a full line or a flush.
// mem_resp follows an accepted write by one cycle; misses stall until the drain completes. Optional read forwarding: WMB_FORWARD_EN.
module write_merge_buffer #(
  parameter int WORD_BYTES = 2,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               mem_write,
  input  logic [ADDR_W-1:0]                  mem_address,
  input  logic [8*WORD_BYTES-1:0]            mem_wdata,
  input  logic [WORD_BYTES-1:0]              mem_byte_enable,
  output logic                               mem_resp,
  input  logic                               flush,
  output logic                               flush_done,
  output logic                               line_write,
  output logic [ADDR_W-1:0]                  line_address,
  output logic [8*WORD_BYTES*LINE_WORDS-1:0] line_data,
  output logic [WORD_BYTES*LINE_WORDS-1:0]   line_mask,
  input  logic                               line_resp,
  output logic                               busy
`ifdef WMB_FORWARD_EN
  ,
  input  logic [ADDR_W-1:0]                  rd_address,
  input  logic [8*WORD_BYTES*LINE_WORDS-1:0] rd_line_in,
  output logic [8*WORD_BYTES*LINE_WORDS-1:0] rd_line_out
`endif
);

  localparam int LINE_BYTES = WORD_BYTES * LINE_WORDS;
  localparam int BOFF_W     = $clog2(WORD_BYTES);
  localparam int WIDX_W     = $clog2(LINE_WORDS);
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int TAG_W      = ADDR_W - OFF_W;
  localparam int LW         = 8 * LINE_BYTES;

  typedef enum logic [1:0] {EMPTY, MERGE, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [LW-1:0]         data_q, data_d;
  logic [LINE_BYTES-1:0] mask_q, mask_d;
  logic                  mem_resp_q, flush_done_q, flush_ack_q;
  logic                  flush_ack_d;

  logic [TAG_W-1:0]      wr_tag;
  logic [WIDX_W-1:0]     word_idx;
  logic                  hit, be_zero, flush_pend, wr_req, accept, merge;
  logic [LW-1:0]         merged_data;
  logic [LINE_BYTES-1:0] merged_mask;

  assign wr_tag   = mem_address[ADDR_W-1:OFF_W];
  assign word_idx = mem_address[OFF_W-1:BOFF_W];
  assign hit      = (wr_tag == tag_q);
  assign be_zero  = (mem_byte_enable == '0);

  // A flush seen in EMPTY is answered once per request; writes wait while it is being answered.
  assign flush_pend = (state_q == EMPTY) && flush && !flush_ack_q;
  assign wr_req     = mem_write && !mem_resp_q && !flush_pend && !flush_done_q;
  assign accept     = wr_req && ((state_q == EMPTY) ||
                                 ((state_q == MERGE) && (hit || be_zero)));
  assign merge      = accept && !be_zero;

  always_comb begin
    merged_data = data_q;
    merged_mask = (state_q == EMPTY) ? '0 : mask_q;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (mem_byte_enable[b]) begin
        merged_data[(int'(word_idx) * WORD_BYTES + b) * 8 +: 8] = mem_wdata[b*8 +: 8];
        merged_mask[int'(word_idx) * WORD_BYTES + b]            = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    data_d      = data_q;
    mask_d      = mask_q;
    flush_ack_d = flush ? (flush_ack_q || flush_pend) : 1'b0;
    case (state_q)
      EMPTY: begin
        if (merge) begin
          tag_d   = wr_tag;
          data_d  = merged_data;
          mask_d  = merged_mask;
          state_d = (&merged_mask) ? DRAIN : MERGE;
        end
      end
      MERGE: begin
        if (merge) begin
          data_d = merged_data;
          mask_d = merged_mask;
        end
        // A hit merges in the same cycle that a flush or full line sends us to DRAIN.
        if ((merge && (&merged_mask)) || flush || (wr_req && !hit && !be_zero))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (line_resp) begin
          state_d = EMPTY;
          mask_d  = '0;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      tag_q        <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      mem_resp_q   <= 1'b0;
      flush_done_q <= 1'b0;
      flush_ack_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      mem_resp_q   <= accept;
      flush_done_q <= flush_pend;
      flush_ack_q  <= flush_ack_d;
    end
  end

  assign mem_resp     = mem_resp_q;
  assign flush_done   = flush_done_q;
  assign line_write   = (state_q == DRAIN);
  assign line_address = {tag_q, {OFF_W{1'b0}}};
  assign line_data    = data_q;
  assign line_mask    = mask_q;
  assign busy         = (state_q != EMPTY);

  logic unused_bits;
`ifdef WMB_FORWARD_EN
  logic rd_hit;
  assign rd_hit = (state_q != EMPTY) && (rd_address[ADDR_W-1:OFF_W] == tag_q);

  always_comb begin
    rd_line_out = rd_line_in;
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (rd_hit && mask_q[b])
        rd_line_out[b*8 +: 8] = data_q[b*8 +: 8];
    end
  end

  assign unused_bits = ^{mem_address[OFF_W-1:0], rd_address[OFF_W-1:0]};
`else
  assign unused_bits = ^mem_address[OFF_W-1:0];
`endif

endmodule

// File: tb/tb_write_merge_buffer.sv
// Directed bench for write_merge_buffer at default parameters (2-byte words, 8-word lines).
module tb_write_merge_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_write;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic [1:0]   mem_byte_enable;
  logic         mem_resp;
  logic         flush;
  logic         flush_done;
  logic         line_write;
  logic [15:0]  line_address;
  logic [127:0] line_data;
  logic [15:0]  line_mask;
  logic         line_resp;
  logic         busy;

  always #5 clk = ~clk;

  write_merge_buffer #(.WORD_BYTES(2), .LINE_WORDS(8), .ADDR_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_resp        (mem_resp),
    .flush           (flush),
    .flush_done      (flush_done),
    .line_write      (line_write),
    .line_address    (line_address),
    .line_data       (line_data),
    .line_mask       (line_mask),
    .line_resp       (line_resp),
    .busy            (busy)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_mask;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] expand(input logic [15:0] m);
    logic [127:0] r;
    r = '0;
    for (int b = 0; b < 16; b++) if (m[b]) r[b*8 +: 8] = 8'hFF;
    return r;
  endfunction

  // Drives one write until acknowledged (bounded), then idles one cycle.
  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be,
                          output int lat);
    mem_address = a; mem_wdata = d; mem_byte_enable = be; mem_write = 1'b1;
    lat = 0;
    do begin step(); lat++; end while (!mem_resp && lat < 20);
    mem_write = 1'b0;
    step();
  endtask

  // Raises flush, checks the drained line, acknowledges it and checks flush_done timing.
  task automatic do_flush(input string name, input logic [15:0] exp_addr,
                          input logic [15:0] exp_mask, output logic [127:0] data);
    int n;
    flush = 1'b1;
    n = 0;
    while (!line_write && n < 20) begin step(); n++; end
    chk({name, "_line_write"}, 128'(line_write), 128'(1));
    chk({name, "_line_address"}, 128'(line_address), 128'(exp_addr));
    chk({name, "_line_mask"}, 128'(line_mask), 128'(exp_mask));
    data = line_data;
    line_resp = 1'b1;
    step();
    line_resp = 1'b0;
    chk({name, "_busy_after_drain"}, 128'(busy), 128'(0));
    chk({name, "_mask_cleared"}, 128'(line_mask), 128'(0));
    n = 0;
    while (!flush_done && n < 20) begin step(); n++; end
    chk({name, "_flush_done_latency"}, 128'(n), 128'(1));
    step();
    chk({name, "_flush_done_single"}, 128'(flush_done), 128'(0));
    flush = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t         tbl [6];
    int           lat, n, pulses, lw_seen;
    logic [127:0] d;
    logic [127:0] exp_line;

    tbl[0] = '{16'h0080, 16'h1111, 2'b11, 16'h0003};
    tbl[1] = '{16'h0083, 16'h2200, 2'b10, 16'h000B};  // word 1, upper byte
    tbl[2] = '{16'h0086, 16'h0033, 2'b01, 16'h004B};
    tbl[3] = '{16'h008E, 16'h4455, 2'b11, 16'hC04B};
    tbl[4] = '{16'h0082, 16'h6677, 2'b00, 16'hC04B};  // empty byte enable: ack only
    tbl[5] = '{16'h0081, 16'hAA99, 2'b01, 16'hC04B};  // overwrite byte 0

    rst = 1'b1; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;
    mem_byte_enable = '0; flush = 1'b0; line_resp = 1'b0;
    step(); step();
    chk("rst_mem_resp", 128'(mem_resp), 128'(0));
    chk("rst_flush_done", 128'(flush_done), 128'(0));
    chk("rst_line_write", 128'(line_write), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_line_mask", 128'(line_mask), 128'(0));
    chk("rst_line_address", 128'(line_address), 128'(0));
    chk("rst_line_data", line_data, 128'(0));
    rst = 1'b0;
    step();

    // 0x0042 is word 1 of line 0x0040 -> bytes 2,3
    do_write(16'h0042, 16'h1234, 2'b11, lat);
    chk("w42_latency", 128'(lat), 128'(1));
    chk("w42_busy", 128'(busy), 128'(1));
    chk("w42_mask", 128'(line_mask), 128'(16'h000C));
    do_flush("w42", 16'h0040, 16'h000C, d);
    chk("w42_data", 128'(d[31:16]), 128'(16'h1234));

    do_write(16'h0040, 16'h00AB, 2'b01, lat);
    chk("split_lat0", 128'(lat), 128'(1));
    do_write(16'h0041, 16'hCD00, 2'b10, lat);
    chk("split_lat1", 128'(lat), 128'(1));
    do_flush("split", 16'h0040, 16'h0003, d);
    chk("split_data", 128'(d[15:0]), 128'(16'hCDAB));

    for (int i = 0; i < 6; i++) begin
      do_write(tbl[i].addr, tbl[i].wdata, tbl[i].be, lat);
      chk($sformatf("tbl%0d_latency", i), 128'(lat), 128'(1));
      chk($sformatf("tbl%0d_mask", i), 128'(line_mask), 128'(tbl[i].exp_mask));
    end
    do_flush("tbl", 16'h0080, 16'hC04B, d);
    chk("tbl_data", d & expand(16'hC04B), 128'h4455_0000_0000_0000_0033_0000_2200_1199);

    // Miss stalls the write until the old line drains
    do_write(16'h0040, 16'h5A5A, 2'b11, lat);
    mem_address = 16'h0050; mem_wdata = 16'hA5A5; mem_byte_enable = 2'b11; mem_write = 1'b1;
    step();
    chk("miss_no_resp", 128'(mem_resp), 128'(0));
    chk("miss_drain", 128'(line_write), 128'(1));
    chk("miss_drain_addr", 128'(line_address), 128'(16'h0040));
    step(); step();
    chk("miss_still_no_resp", 128'(mem_resp), 128'(0));
    line_resp = 1'b1;
    step();
    line_resp = 1'b0;
    n = 0;
    while (!mem_resp && n < 20) begin step(); n++; end
    chk("miss_resp_after_drain", 128'(mem_resp), 128'(1));
    chk("miss_new_tag", 128'(line_address), 128'(16'h0050));
    chk("miss_new_mask", 128'(line_mask), 128'(16'h0003));
    mem_write = 1'b0;
    step();
    do_flush("miss", 16'h0050, 16'h0003, d);
    chk("miss_data", 128'(d[15:0]), 128'(16'hA5A5));

    // Filling every byte drains without a flush
    exp_line = '0;
    for (int i = 0; i < 8; i++) begin
      do_write(16'h0060 + 16'(2*i), 16'h0101 * 16'(i+1), 2'b11, lat);
      exp_line[i*16 +: 16] = 16'h0101 * 16'(i+1);
    end
    chk("full_auto_drain", 128'(line_write), 128'(1));
    chk("full_mask", 128'(line_mask), 128'(16'hFFFF));
    chk("full_addr", 128'(line_address), 128'(16'h0060));
    chk("full_data", line_data, exp_line);
    line_resp = 1'b1;
    step();
    line_resp = 1'b0;
    chk("full_busy_after", 128'(busy), 128'(0));
    step();
    chk("full_no_flush_done", 128'(flush_done), 128'(0));

    // Hit write and flush in the same MERGE cycle
    do_write(16'h0040, 16'h1111, 2'b11, lat);
    mem_address = 16'h0042; mem_wdata = 16'hBEEF; mem_byte_enable = 2'b11;
    mem_write = 1'b1; flush = 1'b1;
    step();
    chk("wf_resp", 128'(mem_resp), 128'(1));
    chk("wf_drain", 128'(line_write), 128'(1));
    chk("wf_mask", 128'(line_mask), 128'(16'h000F));
    chk("wf_data", 128'(line_data[31:0]), 128'(32'hBEEF_1111));
    mem_write = 1'b0; line_resp = 1'b1;
    step();
    line_resp = 1'b0;
    n = 0;
    while (!flush_done && n < 20) begin step(); n++; end
    chk("wf_flush_done_latency", 128'(n), 128'(1));
    flush = 1'b0;
    step(); step();

    // Flush while EMPTY: one pulse, no drain
    flush = 1'b1;
    step();
    chk("fe_flush_done_next", 128'(flush_done), 128'(1));
    pulses = flush_done ? 1 : 0;
    lw_seen = line_write ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (flush_done) pulses++;
      if (line_write) lw_seen++;
    end
    chk("fe_single_pulse", 128'(pulses), 128'(1));
    chk("fe_no_line_write", 128'(lw_seen), 128'(0));
    flush = 1'b0;
    step();

    // Reset during DRAIN
    do_write(16'h0040, 16'h7777, 2'b11, lat);
    flush = 1'b1;
    n = 0;
    while (!line_write && n < 20) begin step(); n++; end
    chk("rd_in_drain", 128'(line_write), 128'(1));
    rst = 1'b1; flush = 1'b0; line_resp = 1'b1;
    step();
    chk("rd_line_write_dropped", 128'(line_write), 128'(0));
    chk("rd_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    step();
    line_resp = 1'b0;
    chk("rd_busy_after", 128'(busy), 128'(0));
    chk("rd_mask", 128'(line_mask), 128'(0));
    chk("rd_line_data", line_data, 128'(0));
    step();
    chk("rd_no_line_write", 128'(line_write), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
